updn_counter_param: RTL and testbench

Parametrised synchronous up/down counter for the datapath timer and address-sequencing logic. Generalises the fixed 4-bit up/down counter with:
- configurable width and counting range [MIN_VAL, MAX_VAL];
- variable step size and enable;
- runtime choice of wrap-around or saturation;
- terminal-count flags and registered overflow/underflow event pulses.

---
 rtl/updn_cnt_pkg.sv | 23 ++
 rtl/updn_next_calc.sv | 70 +++++++
 rtl/updn_counter_param.sv | 148 ++++++++++++++
 tb/tb_updn_counter_param.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/updn_cnt_pkg.sv
// Shared types and configuration check for the parametrised up/down counter.
// Optional feature macro: UPDN_CNT_STICKY_FLAGS_EN (sticky overflow/underflow flags).
package updn_cnt_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // A single step must never jump more than one full range, so one wrap fixup suffices.
  function automatic bit cfg_ok(input int min_val, input int max_val,
                                input int rst_val, input int step_w);
    cfg_ok = (min_val < max_val)
          && ((max_val - min_val + 1) >= ((2 ** step_w) - 1))
          && (rst_val >= min_val) && (rst_val <= max_val);
  endfunction

endpackage

// File: rtl/updn_next_calc.sv
// Combinational next-count calculation: range checks, wrap and saturation arithmetic.
// Pure function of the current count and this edge's direction/step/mode.
module updn_next_calc
  import updn_cnt_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int STEP_W  = 2,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 2 ** WIDTH - 1
) (
  input  logic [WIDTH-1:0]  i_count,
  input  logic [STEP_W-1:0] i_step,
  input  logic              i_updown,
  input  logic              i_sat_mode,
  output logic [WIDTH-1:0]  o_next,
  output logic              o_ovf_evt,
  output logic              o_unf_evt
);

  localparam int XW = WIDTH + 2;

  localparam logic signed [XW-1:0] L_MIN_X  = XW'(MIN_VAL);
  localparam logic signed [XW-1:0] L_MAX_X  = XW'(MAX_VAL);
  localparam logic [WIDTH-1:0]     L_MIN_U  = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0]     L_MAX_U  = WIDTH'(MAX_VAL);
  // Wrap fixups applied modulo 2**WIDTH; the wrapped result always lies in range.
  localparam logic [WIDTH-1:0]     L_UP_OFS = WIDTH'(MIN_VAL - MAX_VAL - 1);
  localparam logic [WIDTH-1:0]     L_DN_OFS = WIDTH'(MAX_VAL - MIN_VAL + 1);

  logic signed [XW-1:0] w_cnt_x;
  logic signed [XW-1:0] w_step_x;
  logic signed [XW-1:0] w_sum;
  logic signed [XW-1:0] w_diff;
  logic [WIDTH-1:0]     w_wrap_up;
  logic [WIDTH-1:0]     w_wrap_dn;
  dir_e                 w_dir;
  mode_e                w_mode;

  assign w_dir     = dir_e'(i_updown);
  assign w_mode    = mode_e'(i_sat_mode);
  assign w_cnt_x   = {2'b00, i_count};
  assign w_step_x  = {{(XW - STEP_W){1'b0}}, i_step};
  assign w_sum     = w_cnt_x + w_step_x;
  assign w_diff    = w_cnt_x - w_step_x;
  assign w_wrap_up = w_sum[WIDTH-1:0] + L_UP_OFS;
  assign w_wrap_dn = w_diff[WIDTH-1:0] + L_DN_OFS;

  // NOTE: every output gets a default before any branch so no path can infer a latch.
  always_comb begin
    o_next    = i_count;
    o_ovf_evt = 1'b0;
    o_unf_evt = 1'b0;
    if (w_dir == DIR_UP) begin
      if (w_sum > L_MAX_X) begin
        o_ovf_evt = 1'b1;
        o_next    = (w_mode == MODE_SAT) ? L_MAX_U : w_wrap_up;
      end else begin
        o_next = w_sum[WIDTH-1:0];
      end
    end else begin
      if (w_diff < L_MIN_X) begin
        o_unf_evt = 1'b1;
        o_next    = (w_mode == MODE_SAT) ? L_MIN_U : w_wrap_dn;
      end else begin
        o_next = w_diff[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/updn_counter_param.sv
// Parametrised up/down counter: registers, rst > load > count > hold priority, load clamp.
// Sticky overflow/underflow flags are built only when UPDN_CNT_STICKY_FLAGS_EN is defined.
module updn_counter_param
  import updn_cnt_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int STEP_W  = 2,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 2 ** WIDTH - 1,
  parameter int RST_VAL = MIN_VAL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              updown,
  input  logic [STEP_W-1:0] step,
  input  logic              sat_mode,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count,
  output logic              at_max,
  output logic              at_min,
  output logic              ovf,
  output logic              unf,
  output logic              ovf_sticky,
  output logic              unf_sticky
);

  localparam int XW = WIDTH + 2;

  localparam logic signed [XW-1:0] L_MIN_X = XW'(MIN_VAL);
  localparam logic signed [XW-1:0] L_MAX_X = XW'(MAX_VAL);
  localparam logic [WIDTH-1:0]     L_MIN_U = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0]     L_MAX_U = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0]     L_RST_U = WIDTH'(RST_VAL);

  if (WIDTH < 2 || STEP_W < 1 || STEP_W > WIDTH || WIDTH > 30) begin : g_bad_width
    $error("updn_counter_param: unsupported WIDTH/STEP_W combination");
  end
  if (!cfg_ok(MIN_VAL, MAX_VAL, RST_VAL, STEP_W)) begin : g_bad_range
    $error("updn_counter_param: MIN_VAL/MAX_VAL/RST_VAL inconsistent with STEP_W");
  end

  logic [WIDTH-1:0]     r_count;
  logic                 r_ovf;
  logic                 r_unf;
  logic [WIDTH-1:0]     w_next;
  logic                 w_ovf_evt;
  logic                 w_unf_evt;
  logic                 w_do_count;
  logic signed [XW-1:0] w_load_x;
  logic [WIDTH-1:0]     w_load_clamped;

  updn_next_calc #(
    .WIDTH   (WIDTH),
    .STEP_W  (STEP_W),
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL)
  ) u_next_calc (
    .i_count    (r_count),
    .i_step     (step),
    .i_updown   (updown),
    .i_sat_mode (sat_mode),
    .o_next     (w_next),
    .o_ovf_evt  (w_ovf_evt),
    .o_unf_evt  (w_unf_evt)
  );

  assign w_do_count = en && (step != '0);

  // Compared in a widened signed domain so full-range limits do not fold into constants.
  assign w_load_x = {2'b00, load_val};

  always_comb begin
    w_load_clamped = load_val;
    if (w_load_x > L_MAX_X) begin
      w_load_clamped = L_MAX_U;
    end else if (w_load_x < L_MIN_X) begin
      w_load_clamped = L_MIN_U;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= L_RST_U;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (load) begin
      r_count <= w_load_clamped;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (w_do_count) begin
      r_count <= w_next;
      r_ovf   <= w_ovf_evt;
      r_unf   <= w_unf_evt;
    end else begin
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end
  end

`ifdef UPDN_CNT_STICKY_FLAGS_EN
  logic r_ovf_sticky;
  logic r_unf_sticky;
  logic w_ovf_set;
  logic w_unf_set;

  // Set on the same edge that raises the pulse, so set beats a simultaneous clear.
  assign w_ovf_set = !load && w_do_count && w_ovf_evt;
  assign w_unf_set = !load && w_do_count && w_unf_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_sticky <= 1'b0;
      r_unf_sticky <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_ovf_sticky <= 1'b1;
      end else if (clr_flags) begin
        r_ovf_sticky <= 1'b0;
      end
      if (w_unf_set) begin
        r_unf_sticky <= 1'b1;
      end else if (clr_flags) begin
        r_unf_sticky <= 1'b0;
      end
    end
  end

  assign ovf_sticky = r_ovf_sticky;
  assign unf_sticky = r_unf_sticky;
`else
  logic w_unused_clr_flags;

  assign w_unused_clr_flags = clr_flags;
  assign ovf_sticky         = 1'b0;
  assign unf_sticky         = 1'b0;
`endif

  assign count  = r_count;
  assign ovf    = r_ovf;
  assign unf    = r_unf;
  assign at_max = (r_count == L_MAX_U);
  assign at_min = (r_count == L_MIN_U);

endmodule

// File: tb/tb_updn_counter_param.sv
// Directed bench for updn_counter_param with WIDTH=4, STEP_W=2, range [2, 11], RST_VAL=2.
// Sticky-flag expectations follow UPDN_CNT_STICKY_FLAGS_EN.
module tb_updn_counter_param;

`ifdef UPDN_CNT_STICKY_FLAGS_EN
  localparam logic STICKY_ON = 1'b1;
`else
  localparam logic STICKY_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       updown = 1'b1;
  logic [1:0] step = 2'd0;
  logic       sat_mode = 1'b0;
  logic       clr_flags = 1'b0;
  logic [3:0] count;
  logic       at_max, at_min, ovf, unf, ovf_sticky, unf_sticky;

  int errors = 0;
  int checks = 0;

  updn_counter_param #(
    .WIDTH(4), .STEP_W(2), .MIN_VAL(2), .MAX_VAL(11), .RST_VAL(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .load_val   (load_val),
    .updown     (updown),
    .step       (step),
    .sat_mode   (sat_mode),
    .clr_flags  (clr_flags),
    .count      (count),
    .at_max     (at_max),
    .at_min     (at_min),
    .ovf        (ovf),
    .unf        (unf),
    .ovf_sticky (ovf_sticky),
    .unf_sticky (unf_sticky)
  );

  always #5 clk = ~clk;

  // Drive one edge's inputs, take the edge, and settle 1 ns past it before sampling.
  task automatic apply(input logic ld, input logic [3:0] lv, input logic e,
                       input logic ud, input logic [1:0] st, input logic sm,
                       input logic cf);
    rst = 1'b0; load = ld; load_val = lv; en = e;
    updown = ud; step = st; sat_mode = sm; clr_flags = cf;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; updown = 1'b1; step = 2'd3; load = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL reset_count: got %0d want 2", count); end
    checks++; if (at_min !== 1'b1 || at_max !== 1'b0) begin errors++; $display("FAIL reset_limits: at_min=%b at_max=%b want 1/0", at_min, at_max); end
    checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin errors++; $display("FAIL reset_pulses: ovf=%b unf=%b want 0/0", ovf, unf); end
    checks++; if (ovf_sticky !== 1'b0 || unf_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky: %b%b want 00", ovf_sticky, unf_sticky); end
  endtask

  task automatic test_wrap_up;
    apply(1'b1, 4'd10, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    checks++; if (count !== 4'd10) begin errors++; $display("FAIL wrap_up_load: got %0d want 10", count); end
    apply(1'b0, 4'd0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0);
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL wrap_up_count: got %0d want 3", count); end
    checks++; if (ovf !== 1'b1 || unf !== 1'b0) begin errors++; $display("FAIL wrap_up_pulse: ovf=%b unf=%b want 1/0", ovf, unf); end
    apply(1'b0, 4'd0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
    checks++; if (count !== 4'd3 || ovf !== 1'b0) begin errors++; $display("FAIL wrap_up_after: count=%0d ovf=%b want 3/0", count, ovf); end
    checks++; if (ovf_sticky !== STICKY_ON) begin errors++; $display("FAIL wrap_up_sticky: got %b want %b", ovf_sticky, STICKY_ON); end
  endtask

  task automatic test_wrap_down;
    apply(1'b0, 4'd0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
    checks++; if (count !== 4'd10) begin errors++; $display("FAIL wrap_dn_count: got %0d want 10", count); end
    checks++; if (unf !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL wrap_dn_pulse: unf=%b ovf=%b want 1/0", unf, ovf); end
    apply(1'b0, 4'd0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
    checks++; if (unf !== 1'b0 || count !== 4'd10) begin errors++; $display("FAIL wrap_dn_after: unf=%b count=%0d want 0/10", unf, count); end
    checks++; if (unf_sticky !== STICKY_ON) begin errors++; $display("FAIL wrap_dn_sticky: got %b want %b", unf_sticky, STICKY_ON); end
  endtask

  task automatic test_saturate;
    apply(1'b1, 4'd10, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
    apply(1'b0, 4'd0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0);
    checks++; if (count !== 4'd11 || at_max !== 1'b1 || ovf !== 1'b1) begin errors++; $display("FAIL sat_up_1: count=%0d at_max=%b ovf=%b want 11/1/1", count, at_max, ovf); end
    apply(1'b0, 4'd0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0);
    checks++; if (count !== 4'd11 || ovf !== 1'b1) begin errors++; $display("FAIL sat_up_2: count=%0d ovf=%b want 11/1", count, ovf); end
    apply(1'b1, 4'd3, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    apply(1'b0, 4'd0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0);
    checks++; if (count !== 4'd2 || at_min !== 1'b1 || unf !== 1'b1) begin errors++; $display("FAIL sat_dn_1: count=%0d at_min=%b unf=%b want 2/1/1", count, at_min, unf); end
    apply(1'b0, 4'd0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0);
    checks++; if (count !== 4'd2 || unf !== 1'b1) begin errors++; $display("FAIL sat_dn_2: count=%0d unf=%b want 2/1", count, unf); end
  endtask

  task automatic test_boundary;
    apply(1'b1, 4'd9, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    apply(1'b0, 4'd0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    checks++; if (count !== 4'd11 || ovf !== 1'b0 || at_max !== 1'b1) begin errors++; $display("FAIL edge_up_exact: count=%0d ovf=%b at_max=%b want 11/0/1", count, ovf, at_max); end
    apply(1'b1, 4'd4, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    apply(1'b0, 4'd0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
    checks++; if (count !== 4'd2 || unf !== 1'b0 || at_min !== 1'b1) begin errors++; $display("FAIL edge_dn_exact: count=%0d unf=%b at_min=%b want 2/0/1", count, unf, at_min); end
    apply(1'b0, 4'd0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
    checks++; if (count !== 4'd3 || at_min !== 1'b0 || at_max !== 1'b0) begin errors++; $display("FAIL mid_step1: count=%0d at_min=%b at_max=%b want 3/0/0", count, at_min, at_max); end
  endtask

  task automatic test_load_clamp;
    apply(1'b1, 4'd14, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0);
    checks++; if (count !== 4'd11 || ovf !== 1'b0) begin errors++; $display("FAIL load_hi_clamp: count=%0d ovf=%b want 11/0", count, ovf); end
    apply(1'b1, 4'd0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
    checks++; if (count !== 4'd2 || unf !== 1'b0) begin errors++; $display("FAIL load_lo_clamp: count=%0d unf=%b want 2/0", count, unf); end
    apply(1'b1, 4'd7, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 4'd0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
      checks++; if (count !== 4'd7 || ovf !== 1'b0) begin errors++; $display("FAIL hold_en0[%0d]: count=%0d ovf=%b want 7/0", i, count, ovf); end
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 4'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      checks++; if (count !== 4'd7 || unf !== 1'b0) begin errors++; $display("FAIL hold_step0[%0d]: count=%0d unf=%b want 7/0", i, count, unf); end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_cnt [3] = '{4'd10, 4'd2, 4'd4};
    logic       exp_ovf [3] = '{1'b0, 1'b1, 1'b0};
    apply(1'b1, 4'd8, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 4'd0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
      checks++; if (count !== exp_cnt[i] || ovf !== exp_ovf[i]) begin errors++; $display("FAIL b2b_up[%0d]: count=%0d ovf=%b want %0d/%b", i, count, ovf, exp_cnt[i], exp_ovf[i]); end
    end
    apply(1'b0, 4'd0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
    checks++; if (count !== 4'd11 || unf !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL b2b_dn: count=%0d unf=%b ovf=%b want 11/1/0", count, unf, ovf); end
  endtask

  task automatic test_reset_mid;
    rst = 1'b1; load = 1'b1; load_val = 4'd9; en = 1'b1; step = 2'd1; updown = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (count !== 4'd2 || unf !== 1'b0) begin errors++; $display("FAIL reset_mid: count=%0d unf=%b want 2/0", count, unf); end
    checks++; if (ovf_sticky !== 1'b0 || unf_sticky !== 1'b0) begin errors++; $display("FAIL reset_mid_sticky: %b%b want 00", ovf_sticky, unf_sticky); end
  endtask

  task automatic test_sticky;
    apply(1'b1, 4'd11, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    apply(1'b0, 4'd0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1);
    checks++; if (count !== 4'd2 || ovf !== 1'b1) begin errors++; $display("FAIL sticky_evt: count=%0d ovf=%b want 2/1", count, ovf); end
    checks++; if (ovf_sticky !== STICKY_ON) begin errors++; $display("FAIL sticky_set_wins: got %b want %b", ovf_sticky, STICKY_ON); end
    apply(1'b0, 4'd0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clear: got %b want 0", ovf_sticky); end
    apply(1'b0, 4'd0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
    checks++; if (count !== 4'd11 || unf !== 1'b1 || unf_sticky !== STICKY_ON) begin errors++; $display("FAIL sticky_unf: count=%0d unf=%b sticky=%b want 11/1/%b", count, unf, unf_sticky, STICKY_ON); end
    apply(1'b0, 4'd0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
    checks++; if (unf_sticky !== STICKY_ON || ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_hold: unf_s=%b ovf_s=%b want %b/0", unf_sticky, ovf_sticky, STICKY_ON); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (unf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_rst: got %b want 0", unf_sticky); end
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_boundary();
    test_load_clamp();
    test_back_to_back();
    test_reset_mid();
    test_sticky();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
